// File: rtl/encoder_al_16_4_seq_pkg.sv
// Shared constants, FSM state type and a population-count helper for the
// active-low 16-to-4 sequential encoder.
package enc_al_pkg;

    localparam int W_CODE  = 4;
    localparam int N_LINES = 2 ** W_CODE;
    localparam int W_CNT   = W_CODE + 1;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_e;

    function automatic logic [W_CNT-1:0] popcount(input logic [N_LINES-1:0] v);
        logic [W_CNT-1:0] c;
        c = '0;
        for (int i = 0; i < N_LINES; i++) begin
            c = c + W_CNT'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/encoder_al_16_4_seq_if.sv
// Request/code bus of the encoder. Optional cnt_out is present only when
// ENCODER_AL_16_4_CNT_EN is defined.
interface encoder_al_16_4_seq_if;
    import enc_al_pkg::*;

    logic [N_LINES-1:0] d_in;
    logic               en_in;
    logic               ready_in;
    logic [W_CODE-1:0]  code_out;
    logic               valid_out;
    logic               idle_out;
`ifdef ENCODER_AL_16_4_CNT_EN
    logic [W_CNT-1:0]   cnt_out;
`endif

    // slave is the encoder itself; master is whoever drives requests and consumes codes
    modport slave (
        input  d_in,
        input  en_in,
        input  ready_in,
        output code_out,
        output valid_out,
`ifdef ENCODER_AL_16_4_CNT_EN
        output cnt_out,
`endif
        output idle_out
    );

    modport master (
        output d_in,
        output en_in,
        output ready_in,
        input  code_out,
        input  valid_out,
`ifdef ENCODER_AL_16_4_CNT_EN
        input  cnt_out,
`endif
        input  idle_out
    );

endinterface

// File: rtl/encoder_al_16_4_seq_pri_enc.sv
// Combinational lowest-set-bit finder: index of the least significant 1 in
// mask_in, and whether any bit is set at all.
module pri_enc_lsb_16_4
    import enc_al_pkg::*;
(
    input  logic [N_LINES-1:0] mask_in,
    output logic [W_CODE-1:0]  idx_out,
    output logic               any_out
);

    // Scan from the top down so the lowest set bit is the last one written
    always_comb begin
        idx_out = '0;
        any_out = |mask_in;
        for (int i = N_LINES - 1; i >= 0; i--) begin
            if (mask_in[i]) begin
                idx_out = W_CODE'(i);
            end
        end
    end

endmodule

// File: rtl/encoder_al_16_4_seq.sv
// Sequential active-low 16-to-4 encoder: snapshots request lines on en_in and
// streams their indices lowest first over valid/ready. Optional remaining-code
// counter under ENCODER_AL_16_4_CNT_EN.
module encoder_al_16_4_seq
    import enc_al_pkg::*;
(
    input  logic                 clk_in,
    input  logic                 rst_in,
    encoder_al_16_4_seq_if.slave bus
);

    state_e             state_q, state_d;
    logic [N_LINES-1:0] pend_q, pend_d;
    logic [N_LINES-1:0] req_mask;
    logic [N_LINES-1:0] clr_onehot;
    logic [N_LINES-1:0] pend_after_clr;
    logic [W_CODE-1:0]  lsb_idx;
    logic               lsb_any;
    logic               capture;
    logic               handshake;

    pri_enc_lsb_16_4 u_pri_enc (
        .mask_in (pend_q),
        .idx_out (lsb_idx),
        .any_out (lsb_any)
    );

    always_comb begin
        req_mask       = ~bus.d_in;
        capture        = (state_q == IDLE) && bus.en_in && (req_mask != '0);
        handshake      = (state_q == EMIT) && bus.ready_in;
        clr_onehot     = N_LINES'(1) << lsb_idx;
        pend_after_clr = pend_q & ~clr_onehot;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (capture) state_d = EMIT;
            EMIT:    if (handshake && (pend_after_clr == '0)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Inputs are only looked at in IDLE, so d_in changes during EMIT cannot leak into pend_q
    always_comb begin
        pend_d = pend_q;
        if (capture) begin
            pend_d = req_mask;
        end else if (handshake) begin
            pend_d = pend_after_clr;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    always_comb begin
        bus.valid_out = (state_q == EMIT);
        bus.idle_out  = (state_q == IDLE);
        bus.code_out  = lsb_any ? lsb_idx : '0;
    end

`ifdef ENCODER_AL_16_4_CNT_EN
    logic [W_CNT-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (capture) begin
            cnt_d = popcount(req_mask);
        end else if (handshake) begin
            cnt_d = cnt_q - W_CNT'(1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.cnt_out = cnt_q;
`endif

endmodule

// File: tb/tb_encoder_al_16_4_seq.sv
// Scoreboard bench for encoder_al_16_4_seq: a queue-based reference model
// predicts codes on capture; a negedge monitor compares whatever the DUT shows.
module tb_encoder_al_16_4_seq;

    logic clk;
    logic rst;
    logic mon_en;
    int   n_checks;
    int   n_pass;
    int   rem;
    int   exp_q[$];

    encoder_al_16_4_seq_if bus();

    encoder_al_16_4_seq dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endfunction

    // Reference model: a snapshot becomes a list of asserted line numbers in ascending order
    always @(posedge clk) begin
        if (rst) begin
            rem = 0;
            exp_q.delete();
        end else if (rem == 0) begin
            if (bus.en_in && (bus.d_in != 16'hFFFF)) begin
                for (int i = 0; i < 16; i++) begin
                    if (!bus.d_in[i]) begin
                        exp_q.push_back(i);
                        rem++;
                    end
                end
            end
        end else if (bus.ready_in) begin
            rem--;
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            chk("valid", int'(bus.valid_out), int'(rem != 0));
            chk("idle", int'(bus.idle_out), int'(rem == 0));
`ifdef ENCODER_AL_16_4_CNT_EN
            chk("cnt", int'(bus.cnt_out), rem);
`endif
            if (rem != 0) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL scoreboard_empty: got no expected code, required one");
                end else begin
                    chk("code", int'(bus.code_out), exp_q[0]);
                    if (bus.ready_in && !rst) void'(exp_q.pop_front());
                end
            end else begin
                chk("code_idle", int'(bus.code_out), 0);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks     = 0;
        n_pass       = 0;
        rem          = 0;
        mon_en       = 1'b0;
        rst          = 1'b1;
        bus.en_in    = 1'b1;
        bus.d_in     = 16'h0000;
        bus.ready_in = 1'b1;

        // Reset held with a would-be capture present
        step(1);
        mon_en = 1'b1;
        step(1);
        rst      = 1'b0;
        bus.en_in = 1'b0;
        bus.d_in  = 16'hFFFF;
        step(2);

        // Single line
        bus.en_in = 1'b1; bus.d_in = 16'hFFFE;
        step(1);
        bus.en_in = 1'b0; bus.d_in = 16'hFFFF;
        step(3);

        // Multi-line, ready high
        bus.en_in = 1'b1; bus.d_in = 16'h7FF6;
        step(1);
        bus.en_in = 1'b0; bus.d_in = 16'hFFFF;
        step(5);

        // Backpressure with d_in/en_in churn during EMIT
        bus.en_in = 1'b1; bus.d_in = 16'h7FF6; bus.ready_in = 1'b0;
        step(1);
        bus.d_in = 16'h0000;
        step(1);
        bus.d_in = 16'hAAAA;
        step(1);
        bus.d_in = 16'h5555;
        step(1);
        bus.ready_in = 1'b1; bus.d_in = 16'h00FF;
        step(1);
        bus.en_in = 1'b0; bus.d_in = 16'hFFFF;
        step(4);

        // Null captures
        bus.en_in = 1'b1; bus.d_in = 16'hFFFF;
        step(2);
        bus.en_in = 1'b0; bus.d_in = 16'h0000;
        step(2);
        bus.d_in = 16'hFFFF;

        // All sixteen lines
        bus.en_in = 1'b1; bus.d_in = 16'h0000;
        step(1);
        bus.en_in = 1'b0; bus.d_in = 16'hFFFF;
        step(18);

        // Reset while code 15 is presented
        bus.en_in = 1'b1; bus.d_in = 16'h7FF6;
        step(1);
        bus.en_in = 1'b0; bus.d_in = 16'hFFFF;
        step(2);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(3);

        // Randomised traffic
        for (int c = 0; c < 400; c++) begin
            bus.en_in    = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 3))
                0:       bus.d_in = 16'hFFFF;
                1:       bus.d_in = 16'($urandom);
                default: bus.d_in = 16'($urandom | $urandom | $urandom);
            endcase
            bus.ready_in = ($urandom_range(0, 3) != 0);
            rst          = ($urandom_range(0, 79) == 0);
            step(1);
        end

        // Drain with a bounded wait
        rst = 1'b0; bus.en_in = 1'b0; bus.d_in = 16'hFFFF; bus.ready_in = 1'b1;
        begin
            int budget;
            budget = 40;
            while (rem != 0 && budget > 0) begin
                step(1);
                budget--;
            end
            n_checks++;
            if (rem == 0) n_pass++;
            else $display("FAIL drain_timeout: got %0d codes pending, required 0", rem);
        end
        step(2);
        mon_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
